// File: rtl/iotdf_pkg.sv
// Shared definitions for the IOTDF sequencing unit: function codes,
// FSM state type, default sizing and function-class helpers.
package iotdf_pkg;

  localparam int DEF_BYTES_PER_WORD  = 16;
  localparam int DEF_WORDS_PER_ROUND = 8;
  localparam int DEF_EVAL_CYC        = 2;
  localparam int DEF_RND_W           = 8;

  localparam logic [2:0] FN_NONE = 3'd0;
  localparam logic [2:0] FN_MAX  = 3'd1;
  localparam logic [2:0] FN_MIN  = 3'd2;
  localparam logic [2:0] FN_AVG  = 3'd3;
  localparam logic [2:0] FN_EXT  = 3'd4;
  localparam logic [2:0] FN_EXC  = 3'd5;
  localparam logic [2:0] FN_PMAX = 3'd6;
  localparam logic [2:0] FN_PMIN = 3'd7;

  typedef enum logic [0:0] {
    RECV = 1'b0,
    EVAL = 1'b1
  } state_t;

  // Functions that can report after every completed word
  function automatic logic fn_is_word(input logic [2:0] fn);
    return (fn == FN_EXT) || (fn == FN_EXC);
  endfunction

  // Functions that always report once per round
  function automatic logic fn_is_round(input logic [2:0] fn);
    return (fn == FN_MAX) || (fn == FN_MIN) || (fn == FN_AVG);
  endfunction

  // Functions that report per round only when the peak moved
  function automatic logic fn_is_peak(input logic [2:0] fn);
    return (fn == FN_PMAX) || (fn == FN_PMIN);
  endfunction

endpackage

// File: rtl/iotdf_wrap_cnt.sv
// Enable-driven counter that wraps to zero after MAX, with a
// terminal-count flag that is high while the count equals MAX.
module iotdf_wrap_cnt #(
  parameter int          W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_r;

  // Advance on enable, wrapping to zero after the terminal value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      if (cnt_r == W'(MAX)) begin
        cnt_r <= {W{1'b0}};
      end else begin
        cnt_r <= cnt_r + W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == W'(MAX));

endmodule

// File: rtl/iotdf_seq_ctrl.sv
// IOTDF control/sequencing: byte/word/round counting, datapath strobes,
// round-end evaluation window and the per-function valid decision.
module iotdf_seq_ctrl
  import iotdf_pkg::*;
#(
  parameter int BYTES_PER_WORD  = DEF_BYTES_PER_WORD,
  parameter int WORDS_PER_ROUND = DEF_WORDS_PER_ROUND,
  parameter int EVAL_CYC        = DEF_EVAL_CYC,
  parameter int RND_W           = DEF_RND_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [2:0]       fn_sel,
  input  logic             dp_hit,
  input  logic             dp_peak_upd,
  output logic             busy,
  output logic             byte_ld,
  output logic [3:0]       byte_idx,
  output logic             round_start,
  output logic             word_done,
  output logic [2:0]       word_idx,
  output logic             round_end,
  output logic [2:0]       fn_act,
  output logic             valid,
  output logic [RND_W-1:0] round_cnt
);

  localparam int EV_W = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;

  state_t          state_r, state_s;
  logic [EV_W-1:0] eval_cnt_r, eval_cnt_s;

  logic             busy_r, word_done_r, round_end_r, valid_r;
  logic [2:0]       word_idx_r, fn_act_r;
  logic             accept_s, word_fin_s, last_byte_s, round_start_s;
  logic             word_valid_s, round_valid_s;
  logic [3:0]       byte_cnt_s;
  logic             byte_tc_s;
  logic [2:0]       word_cnt_s;
  logic             word_tc_s;
  logic [RND_W-1:0] round_cnt_s;
  logic             round_tc_s;

  // A byte is taken only when the host strobes outside the busy window;
  // reset gating keeps byte_ld low while rst is asserted.
  assign accept_s      = in_en & ~busy_r & rst;
  assign word_fin_s    = accept_s & byte_tc_s;
  assign last_byte_s   = word_fin_s & word_tc_s;
  assign round_start_s = accept_s & (byte_cnt_s == 4'd0) & (word_cnt_s == 3'd0);

  iotdf_wrap_cnt #(.W(4), .MAX(BYTES_PER_WORD - 1)) u_byte_cnt (
    .clk(clk), .rst(rst), .en(accept_s), .cnt(byte_cnt_s), .tc(byte_tc_s)
  );

  iotdf_wrap_cnt #(.W(3), .MAX(WORDS_PER_ROUND - 1)) u_word_cnt (
    .clk(clk), .rst(rst), .en(word_fin_s), .cnt(word_cnt_s), .tc(word_tc_s)
  );

  iotdf_wrap_cnt #(.W(RND_W), .MAX((1 << RND_W) - 1)) u_round_cnt (
    .clk(clk), .rst(rst), .en(round_end_r), .cnt(round_cnt_s), .tc(round_tc_s)
  );

  // FSM state and evaluation-window counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= RECV;
      eval_cnt_r <= {EV_W{1'b0}};
    end else begin
      state_r    <= state_s;
      eval_cnt_r <= eval_cnt_s;
    end
  end

  // Next-state: enter EVAL on the round's final byte, leave after EVAL_CYC cycles
  always_comb begin
    state_s    = state_r;
    eval_cnt_s = eval_cnt_r;
    case (state_r)
      RECV: begin
        if (last_byte_s) begin
          state_s    = EVAL;
          eval_cnt_s = {EV_W{1'b0}};
        end else begin
          state_s    = RECV;
        end
      end
      EVAL: begin
        if (eval_cnt_r == EV_W'(EVAL_CYC - 1)) begin
          state_s    = RECV;
          eval_cnt_s = {EV_W{1'b0}};
        end else begin
          eval_cnt_s = eval_cnt_r + EV_W'(1);
        end
      end
      default: begin
        state_s    = RECV;
        eval_cnt_s = {EV_W{1'b0}};
      end
    endcase
  end

  // Word-level hit and round-level result; both land in the same valid register
  // so a coincident word and round report yields a single pulse.
  assign word_valid_s  = word_done_r & fn_is_word(fn_act_r) & dp_hit;
  assign round_valid_s = round_end_r &
                         (fn_is_round(fn_act_r) | (fn_is_peak(fn_act_r) & dp_peak_upd));

  // Registered control outputs and latched function code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= 1'b0;
      word_done_r <= 1'b0;
      word_idx_r  <= 3'd0;
      round_end_r <= 1'b0;
      valid_r     <= 1'b0;
      fn_act_r    <= 3'd0;
    end else begin
      busy_r      <= (state_s == EVAL);
      word_done_r <= word_fin_s;
      round_end_r <= (state_s == EVAL) && (eval_cnt_s == EV_W'(EVAL_CYC - 1));
      valid_r     <= word_valid_s | round_valid_s;
      if (word_fin_s) begin
        word_idx_r <= word_cnt_s;
      end else begin
        word_idx_r <= word_idx_r;
      end
      if (round_start_s) begin
        fn_act_r <= fn_sel;
      end else begin
        fn_act_r <= fn_act_r;
      end
    end
  end

  assign busy        = busy_r;
  assign byte_ld     = accept_s;
  assign byte_idx    = byte_cnt_s;
  assign round_start = round_start_s;
  assign word_done   = word_done_r;
  assign word_idx    = word_idx_r;
  assign round_end   = round_end_r;
  assign fn_act      = fn_act_r;
  assign valid       = valid_r;
  assign round_cnt   = round_cnt_s;

endmodule

// File: tb/tb_iotdf_seq_ctrl.sv
// Bench for iotdf_seq_ctrl: event-scheduling reference model checked every
// cycle, a table of whole-round scenarios, hand-written corner sequences and
// a randomized phase.
module tb_iotdf_seq_ctrl;
  import iotdf_pkg::*;

  localparam int E    = DEF_EVAL_CYC;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_en = 1'b0;
  logic [2:0] fn_sel = 3'd0;
  logic       dp_hit = 1'b0;
  logic       dp_peak_upd = 1'b0;
  logic       busy, byte_ld, round_start, word_done, round_end, valid;
  logic [3:0] byte_idx;
  logic [2:0] word_idx, fn_act;
  logic [7:0] round_cnt;

  iotdf_seq_ctrl dut (
    .clk(clk), .rst(rst), .in_en(in_en), .fn_sel(fn_sel), .dp_hit(dp_hit),
    .dp_peak_upd(dp_peak_upd), .busy(busy), .byte_ld(byte_ld), .byte_idx(byte_idx),
    .round_start(round_start), .word_done(word_done), .word_idx(word_idx),
    .round_end(round_end), .fn_act(fn_act), .valid(valid), .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: future events scheduled by absolute cycle number
  bit m_busy [0:MAXC-1];
  bit m_wd   [0:MAXC-1];
  bit m_re   [0:MAXC-1];
  bit m_val  [0:MAXC-1];
  bit m_rinc [0:MAXC-1];
  int m_widx [0:MAXC-1];
  int cyc, m_bytes, m_fn, m_rcnt;
  int vcount = 0, recount = 0, wdcount = 0, first_wd = -1;

  typedef struct {
    logic [2:0] fn;
    bit   [7:0] mask;
    bit         peak;
    int         exp_valid;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MAXC; i++) begin
      m_busy[i] = 1'b0; m_wd[i] = 1'b0; m_re[i] = 1'b0;
      m_val[i]  = 1'b0; m_rinc[i] = 1'b0; m_widx[i] = 0;
    end
    cyc = 0; m_bytes = 0; m_fn = 0; m_rcnt = 0; first_wd = -1;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model
  task automatic step(input bit en_v, input logic [2:0] fn_v, input bit hit_v, input bit peak_v);
    bit acc;
    @(negedge clk);
    in_en = en_v; fn_sel = fn_v; dp_hit = hit_v; dp_peak_upd = peak_v;
    #1;
    if (cyc >= MAXC - E - 2) begin
      $display("FAIL model_budget cyc=%0d got=%0d want=%0d", cyc, cyc, MAXC - E - 2);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "cycle budget exceeded");
    end
    if (m_rinc[cyc]) m_rcnt = (m_rcnt + 1) % 256;
    acc = en_v && !m_busy[cyc];
    chk("busy", busy, m_busy[cyc]);
    chk("byte_ld", byte_ld, acc);
    chk("byte_idx", byte_idx, m_bytes % 16);
    chk("round_start", round_start, (acc && m_bytes == 0));
    chk("word_done", word_done, m_wd[cyc]);
    if (m_wd[cyc]) chk("word_idx", word_idx, m_widx[cyc]);
    chk("round_end", round_end, m_re[cyc]);
    chk("valid", valid, m_val[cyc]);
    chk("fn_act", fn_act, m_fn);
    chk("round_cnt", round_cnt, m_rcnt);
    if (valid === 1'b1) vcount++;
    if (round_end === 1'b1) recount++;
    if (word_done === 1'b1) begin
      wdcount++;
      if (first_wd < 0) first_wd = cyc;
    end
    if (m_wd[cyc] && (m_fn == 4 || m_fn == 5) && hit_v) m_val[cyc+1] = 1'b1;
    if (m_re[cyc] && ((m_fn >= 1 && m_fn <= 3) || ((m_fn == 6 || m_fn == 7) && peak_v)))
      m_val[cyc+1] = 1'b1;
    if (acc) begin
      if (m_bytes == 0) m_fn = fn_v;
      if (m_bytes % 16 == 15) begin
        m_wd[cyc+1]   = 1'b1;
        m_widx[cyc+1] = m_bytes / 16;
      end
      if (m_bytes == 127) begin
        for (int k = 1; k <= E; k++) m_busy[cyc+k] = 1'b1;
        m_re[cyc+E]     = 1'b1;
        m_rinc[cyc+E+1] = 1'b1;
      end
      m_bytes = (m_bytes + 1) % 128;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0; in_en = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_word_done", word_done, 0);
    chk("rst_round_end", round_end, 0);
    chk("rst_round_cnt", round_cnt, 0);
    chk("rst_fn_act", fn_act, 0);
    chk("rst_byte_idx", byte_idx, 0);
    repeat (2) @(negedge clk);
    model_clear();
    rst = 1'b1;
  endtask

  task automatic feed(input int nb, input logic [2:0] fn);
    int got = 0;
    while (got < nb) begin
      if (!m_busy[cyc]) got++;
      step(1'b1, fn, 1'b0, 1'b0);
    end
  endtask

  task automatic run_round(input logic [2:0] fn, input bit [7:0] mask, input bit peak,
                           output int nv, output int nre, output int nwd);
    int v0 = vcount, r0 = recount, w0 = wdcount, got = 0;
    bit hv;
    while (got < 128) begin
      hv = m_wd[cyc] ? mask[m_widx[cyc]] : 1'b0;
      if (!m_busy[cyc]) got++;
      step(1'b1, fn, hv, peak);
    end
    repeat (E + 3) begin
      hv = m_wd[cyc] ? mask[m_widx[cyc]] : 1'b0;
      step(1'b0, fn, hv, peak);
    end
    nv = vcount - v0; nre = recount - r0; nwd = wdcount - w0;
  endtask

  initial begin
    int nv, nre, nwd, v0;
    tbl[0] = '{3'd1, 8'h00, 1'b0, 1};
    tbl[1] = '{3'd4, 8'h24, 1'b0, 2};
    tbl[2] = '{3'd6, 8'h00, 1'b1, 1};
    tbl[3] = '{3'd6, 8'h00, 1'b0, 0};
    tbl[4] = '{3'd5, 8'hFF, 1'b0, 8};
    tbl[5] = '{3'd0, 8'hFF, 1'b1, 0};
    tbl[6] = '{3'd7, 8'h00, 1'b1, 1};
    tbl[7] = '{3'd3, 8'h00, 1'b0, 1};
    tbl[8] = '{3'd2, 8'hFF, 1'b1, 1};

    model_clear();
    #2;
    chk("init_busy", busy, 0);
    chk("init_byte_ld", byte_ld, 0);
    chk("init_valid", valid, 0);
    chk("init_round_cnt", round_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Whole-round scenarios from the table
    for (int i = 0; i < 9; i++) begin
      run_round(tbl[i].fn, tbl[i].mask, tbl[i].peak, nv, nre, nwd);
      chk("tbl_valid_count", nv, tbl[i].exp_valid);
      chk("tbl_round_end_count", nre, 1);
      chk("tbl_word_done_count", nwd, 8);
      chk("tbl_round_cnt", round_cnt, i + 1);
    end

    // Input gap after byte 7, and strobes presented during busy
    do_reset();
    feed(8, 3'd1);
    repeat (3) begin
      step(1'b0, 3'd1, 1'b0, 1'b0);
      chk("gap_hold_idx", byte_idx, 8);
    end
    feed(120, 3'd1);
    repeat (E) begin
      step(1'b1, 3'd1, 1'b0, 1'b0);
      chk("busy_ignores_in_en", byte_ld, 0);
    end
    step(1'b1, 3'd1, 1'b0, 1'b0);
    chk("post_eval_round_start", round_start, 1);
    chk("post_eval_byte_idx", byte_idx, 0);
    chk("gap_word_done_cycle", first_wd, 19);

    // fn_sel change mid-round does not affect the current round
    do_reset();
    v0 = vcount;
    feed(20, 3'd1);
    feed(108, 3'd2);
    chk("fn_hold_mid", fn_act, 1);
    repeat (E + 2) step(1'b0, 3'd2, 1'b0, 1'b0);
    chk("fn_hold_end", fn_act, 1);
    chk("fn_round_valid", vcount - v0, 1);
    feed(1, 3'd2);
    chk("fn_new_round_start", round_start, 1);
    step(1'b0, 3'd2, 1'b0, 1'b0);
    chk("fn_new_latched", fn_act, 2);

    // Reset during EVAL aborts the pending result
    do_reset();
    feed(128, 3'd1);
    step(1'b0, 3'd1, 1'b0, 1'b0);
    chk("eval_busy_before_rst", busy, 1);
    do_reset();
    run_round(3'd1, 8'h00, 1'b0, nv, nre, nwd);
    chk("after_abort_valid", nv, 1);
    chk("after_abort_round_cnt", round_cnt, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
